// File: rtl/serial_frame_rx.sv
// Receives low-active-windowed serial frames, buffers them in a FIFO, and exposes
// them with control, status and statistics through a Wishbone classic slave.
module serial_frame_rx #(
  parameter int FRAME_BITS = 10,
  parameter int BIT_CYCLES = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        ena_i,
  input  logic        data_i,
  output logic        irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_LOAD  = CW'(BIT_CYCLES/2 - 1);
  localparam logic [CW-1:0] BIT_LOAD   = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, HALF, BITS} rx_state_t;

  rx_state_t             state;
  logic                  ena_r, ena_prev, data_r;
  logic [CW-1:0]         bit_cnt;
  logic [IW-1:0]         bit_idx;
  logic [FRAME_BITS-1:0] shreg;
  logic                  en, ien, ovf;
  logic [CNT_W-1:0]      good_cnt, abort_cnt;
  logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           level;
  logic                  busy, pop_pending;
  logic                  empty, full, push, push_ok, pop, abort;
  logic                  accept, flush, ovf_clr;
  logic [FRAME_BITS-1:0] push_data;
  logic [31:0]           status_word, stats_word;

  assign empty     = (level == '0);
  assign full      = (level == FULL_LEVEL);
  assign push_data = {data_r, shreg[FRAME_BITS-1:1]};
  assign push      = en && (state == BITS) && !ena_r && (bit_cnt == '0) && (bit_idx == LAST_IDX);
  assign pop       = pop_pending;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok   = push && (!full || pop);
  assign abort     = en && (state != IDLE) && ena_r && (bit_idx != '0);

  assign accept  = CYC_I && STB_I && !busy;
  assign flush   = accept && WE_I && (ADR_I[3:2] == 2'd0) && DAT_I[2];
  assign ovf_clr = accept && WE_I && (ADR_I[3:2] == 2'd1) && DAT_I[2];

  assign status_word = {16'b0, 8'(level), 5'b0, ovf, full, empty};
  assign stats_word  = {16'(abort_cnt), 16'(good_cnt)};
  assign irq_o       = ien && !empty;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ena_r    <= 1'b0;
      ena_prev <= 1'b0;
      data_r   <= 1'b0;
    end else begin
      ena_r    <= ena_i;
      ena_prev <= ena_r;
      data_r   <= data_i;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (!en) begin
      state   <= IDLE;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ena_prev && !ena_r) begin
            state   <= HALF;
            bit_cnt <= HALF_LOAD;
            bit_idx <= '0;
          end
        end
        default: begin
          if (ena_r) begin
            state   <= IDLE;
            bit_idx <= '0;
          end else if (bit_cnt != '0) begin
            bit_cnt <= bit_cnt - CW'(1);
          end else begin
            shreg   <= push_data;
            bit_cnt <= BIT_LOAD;
            state   <= BITS;
            bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + IW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push_ok && !flush)
      mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      good_cnt  <= '0;
      abort_cnt <= '0;
      ovf       <= 1'b0;
    end else begin
      if (push_ok)
        good_cnt <= good_cnt + CNT_W'(1);
      if (abort)
        abort_cnt <= abort_cnt + CNT_W'(1);
      if (push && !push_ok)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
    end
  end

  // The DATA pop is deferred to the ACK cycle; the head is captured one cycle earlier.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      ACK_O       <= 1'b0;
      DAT_O       <= '0;
      busy        <= 1'b0;
      pop_pending <= 1'b0;
      en          <= 1'b0;
      ien         <= 1'b0;
    end else begin
      ACK_O       <= accept;
      DAT_O       <= '0;
      pop_pending <= 1'b0;
      if (!STB_I)
        busy <= 1'b0;
      else if (accept)
        busy <= 1'b1;
      if (accept) begin
        if (WE_I) begin
          if (ADR_I[3:2] == 2'd0) begin
            en  <= DAT_I[0];
            ien <= DAT_I[1];
          end
        end else begin
          case (ADR_I[3:2])
            2'd0: DAT_O <= {30'b0, ien, en};
            2'd1: DAT_O <= status_word;
            2'd2: begin
              if (!empty) begin
                DAT_O       <= 32'(mem[rd_ptr]);
                pop_pending <= 1'b1;
              end
            end
            default: DAT_O <= stats_word;
          endcase
        end
      end
    end
  end

  wire unused_ok = &{1'b0, ADR_I[31:4], ADR_I[1:0], DAT_I[31:3]};

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Receive-side counterpart of the team's serial frame transmitter. The transmitter emits 10-bit frames on `data_o`, framed by a low-active `ena_o` window. This block deserializes those frames into a FIFO and exposes them to a Wishbone classic master through a small slave register file. It sits between the transmitter's serial pins and the system bus, replacing bench-side bit capture in the integrated design.

## Interface
- `FRAME_BITS`, 10: bits per frame; LSB is received first.
- `BIT_CYCLES`, 4: `CLK_I` cycles per serial bit. Must be even and ≥ 2.
- `FIFO_DEPTH`, 16: frame FIFO entries. Must be a power of 2.
- `CNT_W`, 16: width of each statistics counter.

- `CLK_I`, in, 1: system clock.
- `RST_I`, in, 1: reset, synchronous, active-high.
- `CYC_I`, in, 1: Wishbone cycle.
- `STB_I`, in, 1: Wishbone strobe.
- `WE_I`, in, 1: Wishbone write enable.
- `ADR_I`, in, 32: byte address. Only `[3:2]` is decoded.
- `DAT_I`, in, 32: write data.
- `DAT_O`, out, 32: read data.
- `ACK_O`, out, 1: transfer acknowledge.
- `ena_i`, in, 1: frame window, active low. Synchronous to `CLK_I`.
- `data_i`, in, 1: serial data. Synchronous to `CLK_I`.
- `irq_o`, out, 1: level interrupt, high while the FIFO is non-empty and `CTRL.ien`=1.

## Operation
- **Registers:**
  - 0x0 `CTRL` (RW)
    - bit0 `en`
    - bit1 `ien`
    - bit2 `flush`: write-1, self-clearing, reads 0.
  - 0x4 `STATUS` (RO, except W1C bit)
    - bit0 `empty`
    - bit1 `full`
    - bit2 `ovf`: sticky; write 1 to clear.
    - `[15:8]` FIFO level
  - 0x8 `DATA` (RO)
    - Read returns `{zeros, frame[FRAME_BITS-1:0]}` and pops one entry.
    - Read while empty returns 0 and does not pop.
  - 0xC `STATS` (RO): `[31:16]` aborted frames, `[15:0]` good frames. Both wrap.
  - Writes to RO addresses are acknowledged and ignored.
- **Bus handshake:**
  - `ACK_O` is a single-cycle pulse, asserted in the cycle after `CYC_I&STB_I` is first seen.
  - No further ACK is issued until `STB_I` has been low for ≥1 cycle. A master holding `STB_I` across several cycles therefore gets exactly one ACK and at most one pop.
  - `DAT_O` is valid in the `ACK_O` cycle and is 0 otherwise.
- **Inputs:** `ena_i` and `data_i` are registered once on entry. All timing below counts from the registered copies.
- **RX FSM** (runs only while `en`=1; clearing `en` forces IDLE and discards any partial frame):
  - IDLE
    - Registered `ena` goes 1→0 → HALF, counter = `BIT_CYCLES/2 - 1`.
  - HALF
    - Counts down to 0.
    - At 0: sample bit 0, bit index = 1, counter = `BIT_CYCLES-1` → BITS.
  - BITS
    - Counts down to 0.
    - At 0: sample bit[index].
    - If index = `FRAME_BITS-1`: push frame, index = 0, stay in BITS. Back-to-back frames are received while `ena` stays low.
  - Any state other than IDLE, when `ena` returns to 1:
    - → IDLE.
    - If index ≠ 0 (partial frame): the bits are discarded and the aborted counter increments.
    - If index = 0: the release is a clean end, and no counter changes.
- **FIFO:**
  - Push while full (and no pop that cycle): frame dropped, `ovf` set. The good-frame counter does not increment.
  - Push and pop in the same cycle: both take effect, level unchanged, no overflow even when full.
  - `flush` empties the FIFO; if it coincides with a push, flush wins. Statistics and `ovf` are unaffected by flush.
- **Reset:**
  - Register, FIFO and counter values: all registers 0, FIFO empty, both counters 0.
  - Outputs: `ACK_O`=0, `DAT_O`=0, `irq_o`=0.
  - FSM returns to IDLE.
  - Reset mid-frame discards the partial frame without counting it.

## Timing
- The falling edge of `ena_i` at clock edge E appears in the registered copy at E+1.
- Bit k is sampled at E+1+`BIT_CYCLES/2`+k·`BIT_CYCLES`, i.e. mid-bit.
- The frame is pushed in the cycle of its last sample. `STATUS.empty` falls and `irq_o` rises one cycle later.
- Bus: `CYC_I&STB_I` sampled at cycle N → `ACK_O` at N+1.
  - A `DATA` pop updates `level` at N+2.
  - A `CTRL` write takes effect at N+1.

## Test plan
- **Reset and idle bus:** reset, then write `CTRL`=0x1 → ACK one cycle after STB; read `STATUS` → 0x00000001.
- **Single frame:** `ena_i` low; send 10 bits of 0x201 LSB-first at 4 cycles/bit; raise `ena_i` → `STATUS.level`=1, `irq_o`=0 (`ien`=0). Read `DATA` → 0x00000201; `STATS` → 0x00000001.
- **Burst:** 100 back-to-back frames with `ena_i` held low and the reader draining → good count 100, aborted count 0, data in send order.
- **Overflow:** 17 frames with no reads → `full`=1, `ovf`=1, level=16, first 16 frames retained. Write `STATUS`=0x4 → `ovf`=0.
- **Abort:** raise `ena_i` after 6 bits → no push, aborted count 1. `STB_I` held 5 cycles on a `DATA` read → exactly one ACK, level drops by exactly 1.
- **Reset mid-frame:** assert `RST_I` after 4 bits; resend frame 0x3FF → FIFO holds only 0x3FF, counters 0/1.
